memory_access_ctrl: RTL and testbench
=====================================

# memory_access_ctrl

Bit-serial access controller sitting directly upstream of the 32-tank mercury-delay-line store. It keeps the single circulation position counter for all tanks and accepts one word-access request at a time. For the addressed tank it generates the tank gating strobes (in/clr/out) and the per-rack serial write data (mib). Read data from the tank output bits (mob) is deserialised into a parallel word and returned on a one-cycle response strobe.

## Interface
Parameters:
- `WORDS_PER_TANK`, 32: short-word slots per tank.
- `SLOT_BITS`, 18: bit positions per short-word slot (17 digits + sandwich digit).

Tank order for all 32-bit tank vectors, bit index 0..31: f1_up t0..t3, f1_down t0..t3, f2_up t0..t3, f2_down t0..t3, r1_up t0..t3, r1_down t0..t3, r2_up t0..t3, r2_down t0..t3.

Ports:
- `clk`  in  1  single clock; one circulation bit position per cycle.
- `rst_n`  in  1  synchronous, active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  controller can accept a request.
- `req_write`  in  1  1 = write, 0 = read.
- `req_long`  in  1  1 = 36-bit long word, 0 = 18-bit short word.
- `req_addr`  in  10  [9:5] tank index, [4:0] short-word slot.
- `req_wdata`  in  36  write word, LSB first on the line.
- `rsp_valid`  out  1  one-cycle completion strobe.
- `rsp_rdata`  out  36  read word; 0 for writes; [35:18] = 0 for short reads.
- `pos`  out  10  circulation position 0..575.
- `tank_in`  out  32  per-tank write-enable gate.
- `tank_clr`  out  32  per-tank recirculation-break gate.
- `tank_out`  out  32  per-tank read gate.
- `tank_mob`  in  32  per-tank serial output bit.
- `rack_mib`  out  4  serial write data to racks [0]=f1, [1]=f2, [2]=r1, [3]=r2.

## Operation
- `pos` is free-running: it increments each cycle and wraps 575 -> 0. It runs regardless of FSM state.
- Slot start is `S = slot*18`. For long words, `slot[0]` is forced to 0, giving a 36-position window `S..S+35`.
- A short word uses the window `S..S+17`.
- Word bit `k` maps to position `S+k`.
- Tank `t = req_addr[9:5]` belongs to rack `t[4:3]`.
- FSM states:
  - IDLE: `req_ready=1`. Handshake is `req_valid & req_ready` at a clock edge. On handshake, latch write, long, address and wdata, and go to WAIT.
  - WAIT: when the next `pos` value equals `S`, go to XFER. This makes `pos==S` on the first XFER cycle.
  - XFER: lasts 18 or 36 cycles. Bit counter `k` runs 0..N-1 with `pos==S+k`.
    - Write, tank t: `tank_in[t]=1`, `tank_clr[t]=1`, and `rack_mib[t[4:3]]=wdata[k]`.
    - Read, tank t: `tank_out[t]=1`, and `tank_mob[t]` is sampled into `rdata[k]` at the end of the cycle.
    - After the last bit, go to RESP.
  - RESP: `rsp_valid=1` for exactly one cycle with `rsp_rdata` valid, then return to IDLE.
- Outside XFER, all bits of `tank_in`, `tank_clr`, `tank_out` and `rack_mib` are 0. At most one tank gate bit is ever high.
- The request inputs are ignored when `req_ready=0`. There is no queueing.

## Timing
- Reset (`rst_n` low at an edge) sets `pos=0`, state IDLE, `req_ready=1`, `rsp_valid=0`, `rsp_rdata=0`, and all tank gates and `rack_mib` to 0.
- Reset mid-XFER aborts the transfer. From the next cycle all gates are 0 and no response is issued; a partial write stays in the tank.
- All outputs are registered. Gates are aligned to `pos`, meaning they are high in exactly the cycles in which `pos` shows the window positions.
- Latency from handshake to the first XFER cycle: `((S - pos_h - 1) mod 576) + 1` cycles, where `pos_h` is `pos` in the handshake cycle. The range is 1..576; when `pos_h == S` the wait is a full 576 cycles.
- `rsp_valid` follows the last XFER cycle by 1 cycle.
- `req_ready` returns high in the cycle after RESP.
- A long window starting at slot 30 covers positions 540..575 and ends exactly at the wrap. Windows never straddle the wrap.
- `tank_mob` is sampled in the same cycle as `pos==S+k`. The tank is required to present bit `p` while `pos==p`.

## Test plan
- Reset then idle: hold `rst_n` low 2 cycles, then release. Expect `pos` to read 0,1,2,… on successive cycles, wrapping 575->0 after 576 cycles, with all gates 0 and `req_ready=1` throughout.
- Short write: handshake at `pos=3`, addr tank 5 (f1_down t1) slot 2, wdata 0x2AAAA. Expect WAIT until `pos=36`, then 18 cycles with `tank_in[5]=tank_clr[5]=1` and `rack_mib[0]` = 0,1,0,1,… (LSB first) at `pos` 36..53. `rsp_valid` pulses at `pos=54` with rdata 0.
- Long read at the wrap: tank 31 slot 31 (forced to 30), tank model returns `pos[0]`. Expect `tank_out[31]` high at `pos` 540..575 and `rsp_rdata=0xAAAAAAAAA` at `pos=0`.
- Back-to-back: write slot 0, then read slot 0 of the same tank. The read returns the written value. `req_ready` is low from handshake through RESP, and a `req_valid` held during busy is not accepted.
- Same-position request: handshake at `pos=36` for slot 2. The first XFER cycle is 576 cycles later at `pos=36`.
- Reset mid-write: assert `rst_n` low during XFER bit 5. Expect gates 0 the next cycle, no `rsp_valid`, and `pos=0` after release.

Source files
------------

// File: rtl/memory_access_ctrl.sv
// Purpose : bit-serial word access controller for the 32-tank mercury delay-line store.
// Latency : handshake to first gated bit = ((S - pos_h - 1) mod 576) + 1 cycles; response 1 cycle after last bit.
// Backpressure: one request in flight; req_ready low from handshake through the response cycle, no queueing.
//
// Ports:
//   clk, rst_n              clock, synchronous active-low reset
//   req_valid/req_ready     request handshake; req_write, req_long, req_addr[9:5]=tank [4:0]=slot, req_wdata
//   rsp_valid, rsp_rdata    one-cycle completion strobe with read word (0 for writes)
//   pos                     free-running circulation position 0..575
//   tank_in/clr/out         per-tank gates, aligned to pos (high exactly while pos is in the window)
//   tank_mob                per-tank serial output bit, presents bit p while pos == p
//   rack_mib                per-rack serial write data, [0]=f1 [1]=f2 [2]=r1 [3]=r2
module memory_access_ctrl #(
    parameter int WORDS_PER_TANK = 32,
    parameter int SLOT_BITS      = 18
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic        req_long,
    input  logic [9:0]  req_addr,
    input  logic [35:0] req_wdata,
    output logic        rsp_valid,
    output logic [35:0] rsp_rdata,
    output logic [9:0]  pos,
    output logic [31:0] tank_in,
    output logic [31:0] tank_clr,
    output logic [31:0] tank_out,
    input  logic [31:0] tank_mob,
    output logic [3:0]  rack_mib
);

    localparam logic [9:0] POS_LAST   = 10'(WORDS_PER_TANK * SLOT_BITS - 1);
    localparam logic [5:0] LAST_SHORT = 6'(SLOT_BITS - 1);
    localparam logic [5:0] LAST_LONG  = 6'(2 * SLOT_BITS - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_XFER,
        ST_RESP
    } state_t;

    state_t      st, st_nxt;
    logic [9:0]  pos_nxt;
    logic        lat_write, lat_long;
    logic [9:0]  lat_addr;
    logic [35:0] lat_wdata;
    logic [5:0]  k, k_nxt;
    logic [35:0] rd_acc, rd_nxt;

    logic        hs;
    logic        cur_write, cur_long;
    logic [9:0]  cur_addr;
    logic [35:0] cur_wdata;
    logic [4:0]  cur_slot;
    logic [9:0]  cur_start;
    logic [5:0]  cur_last_k;
    logic        gate_on;
    logic [31:0] gate_vec;

    assign hs = req_valid & req_ready;

    // On the handshake cycle the request is not latched yet, so the
    // transfer parameters come straight from the request port; this lets a
    // request whose window starts on the very next position go directly to XFER.
    assign cur_write  = hs ? req_write : lat_write;
    assign cur_long   = hs ? req_long  : lat_long;
    assign cur_addr   = hs ? req_addr  : lat_addr;
    assign cur_wdata  = hs ? req_wdata : lat_wdata;

    // Long words occupy an even/odd slot pair, so the slot LSB is dropped.
    assign cur_slot   = {cur_addr[4:1], cur_addr[0] & ~cur_long};
    assign cur_start  = 10'(cur_slot * SLOT_BITS);
    assign cur_last_k = cur_long ? LAST_LONG : LAST_SHORT;

    assign pos_nxt    = (pos == POS_LAST) ? 10'd0 : pos + 10'd1;

    always_comb begin
        st_nxt = st;
        k_nxt  = k;
        rd_nxt = rd_acc;
        case (st)
            ST_IDLE: begin
                if (hs) begin
                    k_nxt  = 6'd0;
                    rd_nxt = 36'd0;
                    st_nxt = (pos_nxt == cur_start) ? ST_XFER : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (pos_nxt == cur_start) begin
                    st_nxt = ST_XFER;
                end
            end
            ST_XFER: begin
                if (!cur_write) begin
                    rd_nxt[k] = tank_mob[cur_addr[9:5]];
                end
                if (k == cur_last_k) begin
                    st_nxt = ST_RESP;
                end else begin
                    k_nxt = k + 6'd1;
                end
            end
            ST_RESP: begin
                st_nxt = ST_IDLE;
            end
            default: begin
                st_nxt = ST_IDLE;
            end
        endcase
    end

    // Gates and write data are registered from the next state so they line
    // up with the registered pos value of the same cycle.
    assign gate_on  = (st_nxt == ST_XFER);
    assign gate_vec = 32'd1 << cur_addr[9:5];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            st        <= ST_IDLE;
            pos       <= 10'd0;
            k         <= 6'd0;
            rd_acc    <= 36'd0;
            lat_write <= 1'b0;
            lat_long  <= 1'b0;
            lat_addr  <= 10'd0;
            lat_wdata <= 36'd0;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= 36'd0;
            tank_in   <= 32'd0;
            tank_clr  <= 32'd0;
            tank_out  <= 32'd0;
            rack_mib  <= 4'd0;
        end else begin
            st     <= st_nxt;
            pos    <= pos_nxt;
            k      <= k_nxt;
            rd_acc <= rd_nxt;
            if (hs) begin
                lat_write <= req_write;
                lat_long  <= req_long;
                lat_addr  <= req_addr;
                lat_wdata <= req_wdata;
            end
            req_ready <= (st_nxt == ST_IDLE);
            rsp_valid <= (st_nxt == ST_RESP);
            // rd_nxt already holds the final bit on the edge entering RESP;
            // it stays all-zero for writes because nothing is sampled.
            rsp_rdata <= (st_nxt == ST_RESP) ? rd_nxt : 36'd0;
            tank_in   <= (gate_on && cur_write)  ? gate_vec : 32'd0;
            tank_clr  <= (gate_on && cur_write)  ? gate_vec : 32'd0;
            tank_out  <= (gate_on && !cur_write) ? gate_vec : 32'd0;
            rack_mib  <= (gate_on && cur_write && cur_wdata[k_nxt]) ? (4'd1 << cur_addr[9:8]) : 4'd0;
        end
    end

endmodule

// File: tb/tb_memory_access_ctrl.sv
// Purpose : directed bench for memory_access_ctrl with a bit-level tank model.
// Latency : transfer timing checked against the handshake-to-window formula per vector.
// Backpressure: req_valid is held (with scrambled fields) while busy to show no second acceptance.
module tb_memory_access_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_write, req_long;
    logic [9:0]  req_addr;
    logic [35:0] req_wdata;
    logic        rsp_valid;
    logic [35:0] rsp_rdata;
    logic [9:0]  pos;
    logic [31:0] tank_in, tank_clr, tank_out, tank_mob;
    logic [3:0]  rack_mib;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    memory_access_ctrl #(.WORDS_PER_TANK(32), .SLOT_BITS(18)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_long(req_long), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .pos(pos),
        .tank_in(tank_in), .tank_clr(tank_clr), .tank_out(tank_out),
        .tank_mob(tank_mob), .rack_mib(rack_mib)
    );

    // Tank model: each tank presents bit p while pos == p and stores the
    // rack write bit at any position where its write gate is open.
    logic mem [32][576];

    always_comb begin
        tank_mob = '0;
        for (int i = 0; i < 32; i++) begin
            tank_mob[i] = (pos < 10'd576) ? mem[i][pos] : 1'b0;
        end
    end

    always @(posedge clk) begin
        for (int i = 0; i < 32; i++) begin
            if (tank_in[i] && pos < 10'd576) mem[i][pos] <= rack_mib[i / 8];
        end
    end

    typedef struct {
        logic        wr;
        logic        lng;
        logic [9:0]  addr;
        logic [35:0] wdata;
        int          hs_pos;
        logic [35:0] exp_rdata;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Advance until pos == p (checked at negedge); counts gate activity seen while idle.
    task automatic wait_pos(input int p, input string tag);
        int stray = 0;
        bit found = 0;
        for (int c = 0; c < 1200; c++) begin
            @(negedge clk);
            if ((tank_in | tank_clr | tank_out) != 0 || rack_mib != 0 || rsp_valid) stray++;
            if (pos == 10'(p)) begin
                found = 1;
                break;
            end
        end
        chk({tag, " pos_reach"}, 64'(found), 64'd1);
        chk({tag, " idle_stray"}, 64'(stray), 64'd0);
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int          s, n_bits, lat, rack, tank;
        int          first_n, first_pos, gcyc, badc, ready_hi, rsp_pos;
        bit          rsp_seen;
        logic [35:0] mib_word, rsp_dat, exp_mib;
        logic [4:0]  slot;
        logic [31:0] e;

        wait_pos(v.hs_pos, tag);
        chk({tag, " ready_at_hs"}, 64'(req_ready), 64'd1);
        req_valid = 1'b1;
        req_write = v.wr;
        req_long  = v.lng;
        req_addr  = v.addr;
        req_wdata = v.wdata;

        slot = v.addr[4:0];
        if (v.lng) slot[0] = 1'b0;
        s      = int'(slot) * 18;
        n_bits = v.lng ? 36 : 18;
        lat    = ((s - v.hs_pos - 1 + 576) % 576) + 1;
        tank   = int'(v.addr[9:5]);
        rack   = tank / 8;
        e      = 32'd1 << tank;
        exp_mib = !v.wr ? 36'd0 : (v.lng ? v.wdata : {18'd0, v.wdata[17:0]});

        first_n = -1; first_pos = -1; gcyc = 0; badc = 0; ready_hi = 0;
        rsp_seen = 0; rsp_pos = -1; rsp_dat = '0; mib_word = '0;

        for (int n = 1; n < 1300; n++) begin
            @(negedge clk);
            if (n == 1) begin
                // keep valid asserted but scramble the fields while busy
                req_write = ~v.wr;
                req_long  = ~v.lng;
                req_addr  = ~v.addr;
                req_wdata = ~v.wdata;
            end
            if (req_ready) ready_hi++;
            if ((tank_in | tank_clr | tank_out) != 0) begin
                if (first_n < 0) begin
                    first_n   = n;
                    first_pos = int'(pos);
                end
                if ((v.wr ? (tank_in == e && tank_clr == e && tank_out == 0)
                          : (tank_out == e && tank_in == 0 && tank_clr == 0))
                    && int'(pos) == s + gcyc && gcyc < 36) begin
                    mib_word[gcyc] = rack_mib[rack];
                    if ((rack_mib & ~(4'd1 << rack)) != 0) badc++;
                    gcyc++;
                end else begin
                    badc++;
                end
            end else if (rack_mib != 0) begin
                badc++;
            end
            if (rsp_valid) begin
                rsp_seen  = 1;
                rsp_pos   = int'(pos);
                rsp_dat   = rsp_rdata;
                req_valid = 1'b0;
                break;
            end
        end
        req_valid = 1'b0;

        chk({tag, " first_lat"},  64'(first_n),   64'(lat));
        chk({tag, " first_pos"},  64'(first_pos), 64'(s));
        chk({tag, " gate_len"},   64'(gcyc),      64'(n_bits));
        chk({tag, " gate_bad"},   64'(badc),      64'd0);
        chk({tag, " mib_word"},   64'(mib_word),  64'(exp_mib));
        chk({tag, " ready_busy"}, 64'(ready_hi),  64'd0);
        chk({tag, " rsp_seen"},   64'(rsp_seen),  64'd1);
        chk({tag, " rsp_pos"},    64'(rsp_pos),   64'((s + n_bits) % 576));
        chk({tag, " rsp_rdata"},  64'(rsp_dat),   64'(v.exp_rdata));
        @(negedge clk);
        chk({tag, " post_ready"}, 64'(req_ready), 64'd1);
        chk({tag, " post_rsp"},   64'(rsp_valid), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   perr;
        int   hit;
        vec_t rv;

        for (int t = 0; t < 32; t++)
            for (int p = 0; p < 576; p++)
                mem[t][p] = (t == 31) ? p[0] : 1'b0;

        //          wr    lng   addr      wdata            hs   exp_rdata
        vecs[0] = '{1'b1, 1'b0, 10'd162,  36'h0_0002_AAAA,   3, 36'h0};          // tank5 slot2 short write
        vecs[1] = '{1'b0, 1'b0, 10'd162,  36'h0,           100, 36'h0_0002_AAAA}; // read it back
        vecs[2] = '{1'b0, 1'b1, 10'd1023, 36'h0,           200, 36'hA_AAAA_AAAA}; // long read at wrap
        vecs[3] = '{1'b1, 1'b1, 10'd388,  36'h9_8765_4321, 500, 36'h0};          // tank12 slot4 long write
        vecs[4] = '{1'b0, 1'b1, 10'd389,  36'h0,            10, 36'h9_8765_4321}; // odd slot forced even
        vecs[5] = '{1'b0, 1'b0, 10'd389,  36'h0,            20, 36'h0_0002_61D9}; // upper half as short
        vecs[6] = '{1'b1, 1'b0, 10'd2,    36'h0_0001_2345,  36, 36'h0};          // same-position: 576 wait
        vecs[7] = '{1'b0, 1'b0, 10'd2,    36'h0,            35, 36'h0_0001_2345}; // 1-cycle wait
        vecs[8] = '{1'b0, 1'b0, 10'd163,  36'h0,           300, 36'h0};          // neighbour slot untouched

        rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_long = 1'b0;
        req_addr = '0; req_wdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        chk("reset pos",   64'(pos),       64'd0);
        chk("reset ready", 64'(req_ready), 64'd1);
        chk("reset rsp",   64'(rsp_valid), 64'd0);
        chk("reset rdata", 64'(rsp_rdata), 64'd0);
        chk("reset gates", 64'(tank_in | tank_clr | tank_out), 64'd0);
        chk("reset mib",   64'(rack_mib),  64'd0);

        perr = 0;
        for (int c = 1; c <= 600; c++) begin
            @(negedge clk);
            if (int'(pos) != c % 576) perr++;
            if ((tank_in | tank_clr | tank_out) != 0 || rack_mib != 0 || !req_ready || rsp_valid) perr++;
            if (c == 576) chk("idle wrap", 64'(pos), 64'd0);
        end
        chk("idle run errors", 64'(perr), 64'd0);

        for (int i = 0; i < 9; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // Reset in the middle of a short write (tank3 slot10, S=180) at bit 5.
        wait_pos(170, "rstmid");
        req_valid = 1'b1; req_write = 1'b1; req_long = 1'b0;
        req_addr = 10'd106; req_wdata = 36'h0_0003_FFFF;
        @(posedge clk);
        #1 req_valid = 1'b0;
        hit = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (pos == 10'd185) begin
                hit = 1;
                break;
            end
        end
        chk("rstmid reach bit5", 64'(hit), 64'd1);
        chk("rstmid gate at bit5", 64'(tank_in), 64'h8);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("rstmid gates off", 64'(tank_in | tank_clr | tank_out), 64'd0);
        chk("rstmid mib off",   64'(rack_mib), 64'd0);
        chk("rstmid pos",       64'(pos),      64'd0);
        chk("rstmid ready",     64'(req_ready), 64'd1);
        perr = 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (int'(pos) != c) perr++;
            if (rsp_valid || (tank_in | tank_clr | tank_out) != 0) perr++;
        end
        chk("rstmid after release", 64'(perr), 64'd0);

        // The six bits written before the reset remain in the tank.
        rv = '{1'b0, 1'b0, 10'd106, 36'h0, 400, 36'h0_0000_003F};
        run_vec(rv, "rstmid readback");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
